ter_accum: RTL and testbench

//  Sequential popcount accumulator for one neuron row of the serial XNOR layer.
//  - Each enabled cycle the layer presents one pre-XNORed weight/input bit (data_in) and a shared bit index (cnt).
//  - The block counts the ones among the first N indices of the row.
//  - Indices >= N and repeated indices are ignored.
//  - acc feeds the layer's sum/offset logic; one instance per non-empty weight row.

---
 rtl/ter_accum_if.sv | 20 ++
 rtl/ter_accum.sv | 58 +++++
 tb/tb_ter_accum.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ter_accum_if.sv
// Row accumulator bus: sequencer-driven bit stream in, registered popcount out.
// TER_ACCUM_SAT_EN adds the sticky saturation flag 'sat'.
interface ter_accum_if #(
  parameter int CntW = 2,
  parameter int AccW = 8
);
  logic            ena;
  logic [CntW-1:0] cnt;
  logic            data_in;
  logic [AccW-1:0] acc;
`ifdef TER_ACCUM_SAT_EN
  logic            sat;

  modport master (output ena, output cnt, output data_in, input acc, input sat);
  modport slave  (input ena, input cnt, input data_in, output acc, output sat);
`else
  modport master (output ena, output cnt, output data_in, input acc);
  modport slave  (input ena, input cnt, input data_in, output acc);
`endif
endinterface

// File: rtl/ter_accum.sv
// In-order popcount of the first N bits of a serial XNOR row; acc is registered, 1-cycle latency.
// Optional TER_ACCUM_SAT_EN: saturate acc at all-ones and raise sticky 'sat'; otherwise acc wraps.
module ter_accum #(
  parameter int N     = 4,
  parameter int Total = 4,
  parameter int AccW  = 8
) (
  input logic        clk,
  input logic        rst,
  ter_accum_if.slave bus
);
  localparam int CntW   = (Total > 1) ? $clog2(Total) : 1;
  localparam int TakenW = $clog2(N + 1);
  localparam int CmpW   = (CntW > TakenW) ? CntW : TakenW;

  logic [TakenW-1:0] r_taken;
  logic [AccW-1:0]   r_acc;
  logic [CmpW-1:0]   w_cnt_ext;
  logic [CmpW-1:0]   w_taken_ext;
  logic              w_accept;

  assign w_cnt_ext   = CmpW'(bus.cnt);
  assign w_taken_ext = CmpW'(r_taken);
  // Only the next expected index is consumed, so replays and skips are ignored.
  assign w_accept    = bus.ena && (w_cnt_ext == w_taken_ext) && (r_taken < TakenW'(N));

`ifdef TER_ACCUM_SAT_EN
  logic r_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      r_taken <= r_taken + 1'b1;
      if (bus.data_in) begin
        if (&r_acc) r_sat <= 1'b1;
        else        r_acc <= r_acc + 1'b1;
      end
    end
  end

  assign bus.sat = r_sat;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken <= '0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_taken <= r_taken + 1'b1;
      r_acc   <= r_acc + AccW'(bus.data_in);
    end
  end
`endif

  assign bus.acc = r_acc;
endmodule

// File: tb/tb_ter_accum.sv
// Drives four differently sized accumulators with one shared stimulus stream and
// compares each against a per-row model of "count ones at indices 0..N-1, in order".
module tb_ter_accum;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ter_accum_if #(.CntW(2), .AccW(8)) if0 ();
  ter_accum_if #(.CntW(2), .AccW(8)) if1 ();
  ter_accum_if #(.CntW(2), .AccW(2)) if2 ();
  ter_accum_if #(.CntW(3), .AccW(8)) if3 ();

  ter_accum #(.N(4), .Total(4), .AccW(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
  ter_accum #(.N(2), .Total(4), .AccW(8)) u1 (.clk(clk), .rst(rst), .bus(if1));
  ter_accum #(.N(4), .Total(4), .AccW(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  ter_accum #(.N(3), .Total(6), .AccW(8)) u3 (.clk(clk), .rst(rst), .bus(if3));

  // Reference: which index the row wants next, how many ones it has seen, saturation flag.
  int m_next[4];
  int m_ones[4];
  int m_sat[4];

  function automatic int n_of(int k);
    case (k)
      0: return 4;
      1: return 2;
      2: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int accw_of(int k);
    return (k == 2) ? 2 : 8;
  endfunction

  function automatic int cntw_of(int k);
    return (k == 3) ? 3 : 2;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int r, input int e, input int c, input int d);
    for (int k = 0; k < 4; k++) begin
      int seen;
      int lim;
      seen = c % (1 << cntw_of(k));
      lim  = (1 << accw_of(k));
      if (r != 0) begin
        m_next[k] = 0;
        m_ones[k] = 0;
        m_sat[k]  = 0;
      end else if (e != 0 && seen == m_next[k] && m_next[k] < n_of(k)) begin
        m_next[k]++;
        if (d != 0) begin
`ifdef TER_ACCUM_SAT_EN
          if (m_ones[k] == lim - 1) m_sat[k] = 1;
          else m_ones[k] = m_ones[k] + 1;
`else
          m_ones[k] = (m_ones[k] + 1) % lim;
`endif
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_u0"}, int'(if0.acc), m_ones[0]);
    chk({tag, "_u1"}, int'(if1.acc), m_ones[1]);
    chk({tag, "_u2"}, int'(if2.acc), m_ones[2]);
    chk({tag, "_u3"}, int'(if3.acc), m_ones[3]);
`ifdef TER_ACCUM_SAT_EN
    chk({tag, "_sat2"}, int'(if2.sat), m_sat[2]);
`endif
  endtask

  // Apply one cycle of stimulus to every row, clock it, then compare all outputs.
  task automatic step(input int r, input int e, input int c, input int d, input string tag);
    logic [2:0] cv;
    cv  = 3'(c);
    rst = (r != 0);
    if0.ena = (e != 0); if0.cnt = cv[1:0]; if0.data_in = (d != 0);
    if1.ena = (e != 0); if1.cnt = cv[1:0]; if1.data_in = (d != 0);
    if2.ena = (e != 0); if2.cnt = cv[1:0]; if2.data_in = (d != 0);
    if3.ena = (e != 0); if3.cnt = cv;      if3.data_in = (d != 0);
    @(posedge clk);
    #1;
    model_edge(r, e, c, d);
    check_all(tag);
  endtask

  initial begin
    int seq;
    int c;
    int exp_t1[4];
    exp_t1 = '{1, 1, 2, 3};
    for (int k = 0; k < 4; k++) begin
      m_next[k] = 0; m_ones[k] = 0; m_sat[k] = 0;
    end
    #2;

    step(1, 0, 0, 0, "reset");
    chk("reset_acc0", int'(if0.acc), 0);

    // Row N=4: data 1,0,1,1 in index order.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i, (i == 1) ? 0 : 1, "t1");
      chk("t1_acc_seq", int'(if0.acc), exp_t1[i]);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 3, 1, "t2_hold");
    chk("t2_no_double", int'(if0.acc), 3);

    // All ones: N=2 row stops at 2, AccW=2 row wraps or saturates.
    step(1, 0, 0, 0, "t3_rst");
    for (int i = 0; i < 4; i++) step(0, 1, i, 1, "t3");
    chk("t3_n2_acc", int'(if1.acc), 2);
    chk("t3_n4_acc", int'(if0.acc), 4);
`ifdef TER_ACCUM_SAT_EN
    chk("t6_sat_acc", int'(if2.acc), 3);
    chk("t6_sat_flag", int'(if2.sat), 1);
`else
    chk("t6_wrap_acc", int'(if2.acc), 0);
`endif

    step(1, 0, 0, 0, "t4_rst");
    step(0, 1, 0, 1, "t4a");
    step(0, 0, 1, 1, "t4b");
    chk("t4_ena_low", int'(if0.acc), 1);
    step(0, 1, 1, 1, "t4c");
    chk("t4_acc", int'(if0.acc), 2);

    // Reset wins over an otherwise acceptable ena cycle.
    step(1, 1, 2, 1, "t5_rst");
    chk("t5_rst_acc", int'(if0.acc), 0);
    for (int i = 0; i < 4; i++) step(0, 1, i, 1, "t5");
    chk("t5_acc", int'(if0.acc), 4);

    seq = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) c = $urandom_range(0, 7);
      else c = seq;
      if ($urandom_range(0, 29) == 0) begin
        step(1, $urandom_range(0, 1), c, $urandom_range(0, 1), "rnd_rst");
        seq = 0;
      end else begin
        int e;
        e = ($urandom_range(0, 3) != 0) ? 1 : 0;
        step(0, e, c, $urandom_range(0, 1), "rnd");
        if (e != 0) seq = (seq + 1) % 8;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
